if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register: fetches the word at the PC
//  over a valid/ready imem port and loads the IF/ID pipeline register (pc, pc+4, instr, valid).
//  Produces the PC stall, which holds the PC during imem waits, ID back-pressure and flush drains.
//  Also produces pc+4 for the next-PC mux, and absorbs branch/jump flushes and ID hazard stalls.
// PARAMETERS
//  XLEN       32        address/instruction width
//  PC_INC     4         sequential PC increment
//  NOP_INSTR  32'h0     instruction injected on bubble/flush/reset
// PORTS
//  clk_i          in   1     clock
//  rst_i          in   1     reset, asynchronous, active-low
//  start_i        in   1     core run enable; sampled only in IDLE
//  pc_i           in   XLEN  current PC (PC register output)
//  stall_id_i     in   1     hazard unit: IF/ID must hold
//  flush_i        in   1     taken branch/jump: squash IF/ID and in-flight fetch
//  imem_req_o     out  1     fetch request valid
//  imem_addr_o    out  XLEN  fetch address
//  imem_ready_i   in   1     request accepted; imem_data_i valid this cycle
//  imem_data_i    in   XLEN  fetched instruction
//  fetch_stall_o  out  1     to PC stall_i: hold PC this cycle
//  pc_plus4_o     out  XLEN  pc_i + PC_INC, to next-PC mux
//  id_valid_o     out  1     IF/ID holds a real instruction
//  id_pc_o        out  XLEN  IF/ID PC
//  id_pc_plus4_o  out  XLEN  IF/ID PC + PC_INC
//  id_instr_o     out  XLEN  IF/ID instruction
// BEHAVIOUR
//  - Reset: state IDLE; id_valid_o=0, id_pc_o=0, id_pc_plus4_o=0, id_instr_o=NOP_INSTR; hold buf cleared.
//  - pc_plus4_o = pc_i + PC_INC, combinational, modulo 2^XLEN (FFFF_FFFC -> 0000_0000).
//  - States: IDLE, FETCH, HOLD, DRAIN. IDLE -> FETCH when start_i=1; start_i ignored after leaving IDLE.
//  - IDLE: imem_req_o=0, fetch_stall_o=1, IF/ID loads bubble.
//  - FETCH: imem_req_o=1, imem_addr_o=pc_i; req_pc_q<=pc_i every cycle.
//    ready & ~stall_id_i & ~flush_i: IF/ID<= {1, pc_i, pc_i+4, imem_data_i}; fetch_stall_o=0; stay FETCH.
//    ready & stall_id_i & ~flush_i: data->hold buf; fetch_stall_o=1; IF/ID unchanged; -> HOLD.
//    ~ready & ~flush_i: fetch_stall_o=1; IF/ID <= bubble if ~stall_id_i, else unchanged.
//    flush_i & ready: data dropped; stay FETCH. flush_i & ~ready: -> DRAIN.
//  - HOLD: imem_req_o=0. ~stall_id_i: IF/ID<=hold buf, fetch_stall_o=0, -> FETCH; else fetch_stall_o=1.
//  - DRAIN: imem_req_o=1, imem_addr_o=req_pc_q (stable until accepted, as handshake requires).
//    ready: data dropped, -> FETCH. fetch_stall_o=1 (PC holds branch target).
//  - flush_i (any state but IDLE) has priority over stall_id_i and ready: IF/ID <= bubble next edge,
//    hold buf discarded, fetch_stall_o forced 0 so PC loads the target. flush in HOLD -> FETCH; in DRAIN stays DRAIN.
//  - Bubble = {valid 0, pc 0, pc+4 0, NOP_INSTR}. Once accepted, imem_req_o/imem_addr_o never change before ready.
//  - Latency: imem ready in the cycle after request -> instr visible on id_* 1 edge after ready.
//  - Reset mid-transaction: immediate return to IDLE; imem must share rst_i.
// STRUCTURE
//  - Shared package: fetch state encoding, NOP_INSTR, PC_INC constants.
//  - Sub-module if_id_reg: IF/ID register with load/hold/flush controls; FSM + hold buf in top.
// TESTING
//  - Reset then start_i=1, pc_i=0, ready same cycle: id_pc_o=0, id_pc_plus4_o=4, id_valid_o=1, fetch_stall_o=0.
//  - imem ready after 3 wait cycles at pc 0x40: fetch_stall_o=1 x3, IF/ID bubbles, then instr loaded, pc+4=0x44.
//  - ready with stall_id_i=1 for 2 cycles: HOLD, id_* unchanged, then buffered instr loaded when stall drops.
//  - flush_i during wait at pc 0x80: fetch_stall_o=0 that cycle, addr stays 0x80 until ready, data dropped;
//    next fetch at target 0x200.
//  - flush_i and stall_id_i same cycle: IF/ID bubble (flush wins); pc_i=FFFF_FFFC -> pc_plus4_o=0.
//  - rst_i low while in DRAIN: all id_* at reset values immediately, imem_req_o=0.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Imported by the fetch stage, its IF/ID register and the imem interface users.
package if_fetch_stage_pkg;

   localparam int          XLEN_DEF      = 32;
   localparam int          PC_INC_DEF    = 4;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory valid/ready port between the fetch stage (master) and imem (slave).
// Once req is raised, req/addr stay put until the slave answers with ready.
interface if_fetch_stage_if #(
   parameter int XLEN = 32
);

   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;
   logic [XLEN-1:0] data;

   modport master (output req, output addr, input ready, input data);
   modport slave  (input req, input addr, output ready, output data);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: a bubble has priority over a load, otherwise the contents hold.
// A load captures pc, pc + PC_INC and the instruction as one valid entry.
module if_id_reg
   import if_fetch_stage_pkg::*;
#(
   parameter int              XLEN      = XLEN_DEF,
   parameter int              PC_INC    = PC_INC_DEF,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            bubble_i,
   input  logic            load_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic [XLEN-1:0] instr_o
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_o    <= 1'b0;
         pc_o       <= '0;
         pc_plus4_o <= '0;
         instr_o    <= NOP_INSTR;
      end else if (bubble_i) begin
         valid_o    <= 1'b0;
         pc_o       <= '0;
         pc_plus4_o <= '0;
         instr_o    <= NOP_INSTR;
      end else if (load_i) begin
         valid_o    <= 1'b1;
         pc_o       <= pc_i;
         pc_plus4_o <= pc_i + XLEN'(PC_INC);
         instr_o    <= instr_i;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the imem handshake, loads IF/ID, and stalls the PC while
// waiting on imem, on ID back-pressure or while draining a fetch squashed by a flush.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int              XLEN      = XLEN_DEF,
   parameter int              PC_INC    = PC_INC_DEF,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic                     stall_id_i,
   input  logic                     flush_i,
   if_fetch_stage_if.master         imem,
   output logic                     fetch_stall_o,
   output logic [XLEN-1:0]          pc_plus4_o,
   output logic                     id_valid_o,
   output logic [XLEN-1:0]          id_pc_o,
   output logic [XLEN-1:0]          id_pc_plus4_o,
   output logic [XLEN-1:0]          id_instr_o
);

   fetch_state_e    state_q, state_d;
   logic            req_q;
   logic [XLEN-1:0] req_pc_q;
   logic [XLEN-1:0] hold_pc_q;
   logic [XLEN-1:0] hold_instr_q;
   logic            id_bubble;
   logic            id_load;
   logic            use_hold;
   logic            hold_capture;

   assign pc_plus4_o = pc_i + XLEN'(PC_INC);
   assign imem.req   = req_q;

   // A flush always wins: IF/ID bubbles and the PC is released to load the branch target,
   // while an unanswered request keeps its address alive in DRAIN until imem accepts it.
   always_comb begin
      state_d       = state_q;
      fetch_stall_o = 1'b1;
      id_bubble     = 1'b0;
      id_load       = 1'b0;
      use_hold      = 1'b0;
      hold_capture  = 1'b0;
      imem.addr     = pc_i;
      unique case (state_q)
         ST_IDLE: begin
            id_bubble = 1'b1;
            if (start_i) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (flush_i) begin
               fetch_stall_o = 1'b0;
               id_bubble     = 1'b1;
               if (!imem.ready) state_d = ST_DRAIN;
            end else if (imem.ready && !stall_id_i) begin
               fetch_stall_o = 1'b0;
               id_load       = 1'b1;
            end else if (imem.ready) begin
               hold_capture = 1'b1;
               state_d      = ST_HOLD;
            end else if (!stall_id_i) begin
               id_bubble = 1'b1;
            end
         end
         ST_HOLD: begin
            if (flush_i) begin
               fetch_stall_o = 1'b0;
               id_bubble     = 1'b1;
               state_d       = ST_FETCH;
            end else if (!stall_id_i) begin
               fetch_stall_o = 1'b0;
               id_load       = 1'b1;
               use_hold      = 1'b1;
               state_d       = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            imem.addr = req_pc_q;
            if (flush_i) begin
               fetch_stall_o = 1'b0;
               id_bubble     = 1'b1;
            end else begin
               if (imem.ready) state_d = ST_FETCH;
               if (!stall_id_i) id_bubble = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         req_q        <= 1'b0;
         req_pc_q     <= '0;
         hold_pc_q    <= '0;
         hold_instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         req_q   <= (state_d == ST_FETCH) || (state_d == ST_DRAIN);
         if (state_q == ST_FETCH) req_pc_q <= pc_i;
         if (flush_i && (state_q != ST_IDLE)) begin
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
         end else if (hold_capture) begin
            hold_pc_q    <= pc_i;
            hold_instr_q <= imem.data;
         end
      end
   end

   if_id_reg #(
      .XLEN      (XLEN),
      .PC_INC    (PC_INC),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .bubble_i   (id_bubble),
      .load_i     (id_load),
      .pc_i       (use_hold ? hold_pc_q : pc_i),
      .instr_i    (use_hold ? hold_instr_q : imem.data),
      .valid_o    (id_valid_o),
      .pc_o       (id_pc_o),
      .pc_plus4_o (id_pc_plus4_o),
      .instr_o    (id_instr_o)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed cycle table, reset during a drain, then random traffic
// against a reference model built from outstanding-request / buffered-instruction bookkeeping.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef struct {
      logic        start, stall_id, flush, ready;
      logic [31:0] pc, data;
      logic        exp_stall, exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc, exp_pc4, exp_instr;
   } vec_t;

   typedef struct packed {
      logic        v;
      logic [31:0] pc, pc4, instr;
   } ifid_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic        stall_id_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        fetch_stall_o;
   logic [31:0] pc_plus4_o;
   logic        id_valid_o;
   logic [31:0] id_pc_o, id_pc_plus4_o, id_instr_o;

   int checks = 0;
   int errors = 0;

   if_fetch_stage_if #(.XLEN(32)) imem ();

   if_fetch_stage dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .pc_i          (pc_i),
      .stall_id_i    (stall_id_i),
      .flush_i       (flush_i),
      .imem          (imem),
      .fetch_stall_o (fetch_stall_o),
      .pc_plus4_o    (pc_plus4_o),
      .id_valid_o    (id_valid_o),
      .id_pc_o       (id_pc_o),
      .id_pc_plus4_o (id_pc_plus4_o),
      .id_instr_o    (id_instr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic applyStimulus(input logic st, input logic [31:0] pc, input logic sid,
                                input logic fl, input logic rdy, input logic [31:0] dat);
      @(negedge clk_i);
      start_i         = st;
      pc_i            = pc;
      stall_id_i      = sid;
      flush_i         = fl;
      imem.ready      = rdy;
      imem.data       = dat;
      #1;
   endtask

   task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s step %0d got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic checkId(input int idx, input ifid_t exp);
      checkOutput("id_valid", idx, {31'b0, id_valid_o}, {31'b0, exp.v});
      checkOutput("id_pc", idx, id_pc_o, exp.pc);
      checkOutput("id_pc_plus4", idx, id_pc_plus4_o, exp.pc4);
      checkOutput("id_instr", idx, id_instr_o, exp.instr);
   endtask

   // Reference model: running flag, an in-flight request squashed by a flush, and at most
   // one fetched instruction parked while ID back-pressures.
   bit          m_run;
   bit          m_squash;
   logic [31:0] m_req_pc;
   ifid_t       m_ifid;
   ifid_t       m_buf[$];

   initial begin
      vec_t        vec[18];
      ifid_t       bubble;
      logic        st, sid, fl, rdy, e_stall, e_req;
      logic [31:0] dat, e_addr, pc_r;

      bubble = '{1'b0, 32'h0, 32'h0, NOP};
      imem.ready = 1'b0;
      imem.data  = '0;

      vec[0]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0,        32'h0,        1'b1,1'b0, 32'h0,        1'b0, 32'h0,        32'h0,   NOP};
      vec[1]  = '{1'b0,1'b0,1'b0,1'b1, 32'h0,        32'h1111_0013,1'b0,1'b1, 32'h0,        1'b1, 32'h0,        32'h4,   32'h1111_0013};
      vec[2]  = '{1'b0,1'b0,1'b0,1'b0, 32'h40,       32'hDEAD_BEEF,1'b1,1'b1, 32'h40,       1'b0, 32'h0,        32'h0,   NOP};
      vec[3]  = '{1'b0,1'b0,1'b0,1'b0, 32'h40,       32'hDEAD_BEEF,1'b1,1'b1, 32'h40,       1'b0, 32'h0,        32'h0,   NOP};
      vec[4]  = '{1'b0,1'b0,1'b0,1'b0, 32'h40,       32'hDEAD_BEEF,1'b1,1'b1, 32'h40,       1'b0, 32'h0,        32'h0,   NOP};
      vec[5]  = '{1'b0,1'b0,1'b0,1'b1, 32'h40,       32'h2222_0093,1'b0,1'b1, 32'h40,       1'b1, 32'h40,       32'h44,  32'h2222_0093};
      vec[6]  = '{1'b0,1'b1,1'b0,1'b1, 32'h44,       32'h3333_0113,1'b1,1'b1, 32'h44,       1'b1, 32'h40,       32'h44,  32'h2222_0093};
      vec[7]  = '{1'b0,1'b1,1'b0,1'b0, 32'h44,       32'h0,        1'b1,1'b0, 32'h44,       1'b1, 32'h40,       32'h44,  32'h2222_0093};
      vec[8]  = '{1'b0,1'b0,1'b0,1'b0, 32'h44,       32'h0,        1'b0,1'b0, 32'h44,       1'b1, 32'h44,       32'h48,  32'h3333_0113};
      vec[9]  = '{1'b0,1'b0,1'b0,1'b0, 32'h80,       32'h0,        1'b1,1'b1, 32'h80,       1'b0, 32'h0,        32'h0,   NOP};
      vec[10] = '{1'b0,1'b0,1'b1,1'b0, 32'h80,       32'h0,        1'b0,1'b1, 32'h80,       1'b0, 32'h0,        32'h0,   NOP};
      vec[11] = '{1'b0,1'b0,1'b0,1'b0, 32'h200,      32'h0,        1'b1,1'b1, 32'h80,       1'b0, 32'h0,        32'h0,   NOP};
      vec[12] = '{1'b0,1'b0,1'b0,1'b1, 32'h200,      32'h4444_0193,1'b1,1'b1, 32'h80,       1'b0, 32'h0,        32'h0,   NOP};
      vec[13] = '{1'b0,1'b0,1'b0,1'b1, 32'h200,      32'h5555_0213,1'b0,1'b1, 32'h200,      1'b1, 32'h200,      32'h204, 32'h5555_0213};
      vec[14] = '{1'b0,1'b1,1'b1,1'b1, 32'h204,      32'h6666_0293,1'b0,1'b1, 32'h204,      1'b0, 32'h0,        32'h0,   NOP};
      vec[15] = '{1'b0,1'b0,1'b0,1'b1, 32'hFFFF_FFFC,32'h7777_0313,1'b0,1'b1, 32'hFFFF_FFFC,1'b1, 32'hFFFF_FFFC,32'h0,   32'h7777_0313};
      vec[16] = '{1'b0,1'b0,1'b1,1'b0, 32'h300,      32'h0,        1'b0,1'b1, 32'h300,      1'b0, 32'h0,        32'h0,   NOP};
      vec[17] = '{1'b1,1'b0,1'b0,1'b0, 32'h400,      32'h0,        1'b1,1'b1, 32'h300,      1'b0, 32'h0,        32'h0,   NOP};

      #12;
      checkId(-1, bubble);
      checkOutput("req_reset", -1, {31'b0, imem.req}, 32'h0);
      checkOutput("stall_reset", -1, {31'b0, fetch_stall_o}, 32'h1);
      @(negedge clk_i);
      rst_i = 1'b1;

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vec[i].start, vec[i].pc, vec[i].stall_id, vec[i].flush, vec[i].ready,
                       vec[i].data);
         checkOutput("fetch_stall", i, {31'b0, fetch_stall_o}, {31'b0, vec[i].exp_stall});
         checkOutput("imem_req", i, {31'b0, imem.req}, {31'b0, vec[i].exp_req});
         if (vec[i].exp_req) checkOutput("imem_addr", i, imem.addr, vec[i].exp_addr);
         checkOutput("pc_plus4", i, pc_plus4_o, vec[i].pc + 32'd4);
         @(posedge clk_i);
         #1;
         checkId(i, '{vec[i].exp_valid, vec[i].exp_pc, vec[i].exp_pc4, vec[i].exp_instr});
      end

      // Asynchronous reset while a squashed request is still draining.
      #2;
      rst_i = 1'b0;
      #1;
      checkOutput("req_async_reset", 100, {31'b0, imem.req}, 32'h0);
      checkOutput("stall_async_reset", 100, {31'b0, fetch_stall_o}, 32'h1);
      checkId(100, bubble);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      checkOutput("req_idle_after_reset", 101, {31'b0, imem.req}, 32'h0);
      checkId(101, bubble);

      m_run = 1'b0;
      m_squash = 1'b0;
      m_req_pc = '0;
      m_ifid = bubble;
      m_buf.delete();
      pc_r = 32'h0000_1000;

      for (int c = 0; c < 400; c++) begin
         st  = ($urandom_range(0, 3) == 0);
         sid = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         rdy = 1'($urandom_range(0, 1));
         dat = $urandom;
         applyStimulus(st, pc_r, sid, fl, rdy, dat);

         e_req  = m_run && (m_buf.size() == 0);
         e_addr = m_squash ? m_req_pc : pc_r;
         if (!m_run)                e_stall = 1'b1;
         else if (fl)               e_stall = 1'b0;
         else if (m_buf.size() > 0) e_stall = sid;
         else if (m_squash)         e_stall = 1'b1;
         else                       e_stall = !(rdy && !sid);

         checkOutput("rnd_fetch_stall", 200 + c, {31'b0, fetch_stall_o}, {31'b0, e_stall});
         checkOutput("rnd_imem_req", 200 + c, {31'b0, imem.req}, {31'b0, e_req});
         if (e_req) checkOutput("rnd_imem_addr", 200 + c, imem.addr, e_addr);
         checkOutput("rnd_pc_plus4", 200 + c, pc_plus4_o, pc_r + 32'd4);

         if (!m_run) begin
            m_ifid = bubble;
            m_run  = st;
         end else if (fl) begin
            m_ifid = bubble;
            if (m_buf.size() > 0) m_buf.delete();
            else if (!m_squash && !rdy) begin
               m_squash = 1'b1;
               m_req_pc = pc_r;
            end
         end else if (m_buf.size() > 0) begin
            if (!sid) m_ifid = m_buf.pop_front();
         end else if (m_squash) begin
            if (rdy) m_squash = 1'b0;
            if (!sid) m_ifid = bubble;
         end else if (rdy) begin
            if (sid) m_buf.push_back('{1'b1, pc_r, pc_r + 32'd4, dat});
            else     m_ifid = '{1'b1, pc_r, pc_r + 32'd4, dat};
         end else if (!sid) begin
            m_ifid = bubble;
         end

         @(posedge clk_i);
         #1;
         checkId(200 + c, m_ifid);

         if (!e_stall) begin
            if (fl) pc_r = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            else    pc_r = pc_r + 32'd4;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
